awgn_sincos_sched: RTL and testbench

Issue scheduler and output buffer for the sin/cos stage of the AWGN Box-Muller datapath. It accepts 16-bit uniform words from the URNG over a valid/ready handshake and drives them onto the free-running sincos pipeline's `u1` input. It tracks in-flight samples with a latency-matched valid shift register and captures the returned `g0`/`g1` pair into a small first-word-fall-through FIFO. Issue is credit-gated, so no sample is ever lost under downstream backpressure.

---
 rtl/awgn_sincos_sched.sv | 122 ++++++++++++
 tb/tb_awgn_sincos_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awgn_sincos_sched.sv
`timescale 1ns/1ps
// Issue scheduler and output FIFO for the Box-Muller sin/cos stage.
// Credit-gated issue into a free-running pipeline; results land in a fall-through FIFO.
module awgn_sincos_sched #(
  parameter int W        = 16,
  parameter int PIPE_LAT = 2,
  parameter int DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         urng_valid,
  input  logic [W-1:0] urng_data,
  output logic         urng_ready,
  output logic [W-1:0] u1,
  input  logic [W-1:0] g0_in,
  input  logic [W-1:0] g1_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_g0,
  output logic [W-1:0] out_g1,
  output logic         busy,
  output logic [15:0]  pair_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + PIPE_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PIPE_LAT-1:0] r_vld;
  logic [CW-1:0]       r_inflight;
  logic [CW-1:0]       r_occ;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [W-1:0]        r_mem_g0 [DEPTH];
  logic [W-1:0]        r_mem_g1 [DEPTH];
  logic [W-1:0]        r_u1;
  logic [15:0]         r_pair_cnt;

  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [CW:0]         w_credit_used;

  // Credit counts everything already committed: buffered pairs plus samples in the pipe.
  assign w_credit_used = {1'b0, r_occ} + {1'b0, r_inflight};
  assign urng_ready    = (r_state == S_RUN) && (w_credit_used < (CW+1)'(DEPTH));
  assign w_issue       = urng_valid && urng_ready;
  assign w_push        = r_vld[PIPE_LAT-1];
  assign out_valid     = (r_occ != '0);
  assign w_pop         = out_valid && out_ready;

  // Head is masked when empty so the outputs read zero after reset without clearing storage.
  assign out_g0   = out_valid ? r_mem_g0[r_rptr] : '0;
  assign out_g1   = out_valid ? r_mem_g1[r_rptr] : '0;
  assign u1       = r_u1;
  assign busy     = (r_state != S_IDLE);
  assign pair_cnt = r_pair_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = (r_inflight != '0) ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (enable)                  w_state_nxt = S_RUN;
        else if (r_inflight == '0)   w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_vld      <= '0;
      r_inflight <= '0;
      r_occ      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_u1       <= '0;
      r_pair_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= (r_vld << 1) | PIPE_LAT'(w_issue);
      if (w_issue) r_u1 <= urng_data;

      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr     <= r_rptr + AW'(1);
        r_pair_cnt <= r_pair_cnt + 16'd1;
      end
    end
  end

  // FIFO storage carries data only; validity is tracked by r_occ.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_g0[r_wptr] <= g0_in;
      r_mem_g1[r_wptr] <= g1_in;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    w_push |-> (r_occ != CW'(DEPTH)));

endmodule

// File: tb/tb_awgn_sincos_sched.sv
`timescale 1ns/1ps
// Self-checking bench for awgn_sincos_sched with a delay-line stand-in for the sincos pipeline.
module tb_awgn_sincos_sched;

  localparam int W        = 16;
  localparam int PIPE_LAT = 2;
  localparam int DEPTH    = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         urng_valid;
  logic [W-1:0] urng_data;
  logic         urng_ready;
  logic [W-1:0] u1;
  logic [W-1:0] g0_in;
  logic [W-1:0] g1_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_g0;
  logic [W-1:0] out_g1;
  logic         busy;
  logic [15:0]  pair_cnt;

  always #5 clk = ~clk;

  // u1 is already one register deep, so one more stage gives PIPE_LAT=2.
  logic [W-1:0] u1_d;
  always @(posedge clk) u1_d <= u1;
  assign g0_in = u1_d;
  assign g1_in = ~u1_d;

  awgn_sincos_sched #(.W(W), .PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .urng_valid(urng_valid), .urng_data(urng_data), .urng_ready(urng_ready),
    .u1(u1), .g0_in(g0_in), .g1_in(g1_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_g0(out_g0), .out_g1(out_g1),
    .busy(busy), .pair_cnt(pair_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int n_pop   = 0;
  logic [W-1:0]   acc_q[$];
  int             acc_edge_q[$];
  logic [2*W-1:0] pop_q[$];
  int             pop_edge_q[$];

  function automatic logic [2*W-1:0] exp_pair(input logic [W-1:0] w);
    return {w, ~w};
  endfunction

  // Records handshakes that will complete at the coming edge, then advances one cycle.
  task automatic tick();
    if (urng_valid && urng_ready) begin
      acc_q.push_back(urng_data);
      acc_edge_q.push_back(cyc + 1);
      n_acc++;
    end
    if (out_valid && out_ready) begin
      pop_q.push_back({out_g0, out_g1});
      pop_edge_q.push_back(cyc + 1);
      n_pop++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    acc_q.delete(); acc_edge_q.delete(); pop_q.delete(); pop_edge_q.delete();
    n_acc = 0; n_pop = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; urng_valid = 1'b0; urng_data = '0; out_ready = 1'b0;
    #180;
    n_tests++; if (u1 !== 16'h0000) begin n_fail++; $display("FAIL reset_u1: got %h want 0000", u1); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if ({out_g0, out_g1} !== 32'h0) begin n_fail++; $display("FAIL reset_out_g: got %h want 0", {out_g0, out_g1}); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (pair_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_pair_cnt: got %h want 0", pair_cnt); end
    n_tests++; if (urng_ready !== 1'b0) begin n_fail++; $display("FAIL reset_urng_ready: got %b want 0", urng_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cyc = 0;
    urng_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      urng_data = W'($urandom);
      n_tests++;
      if (urng_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_no_ready: ready=%b busy=%b want 0/0", urng_ready, busy);
      end
      tick();
    end
    urng_valid = 1'b0;
    n_tests++; if (n_acc != 0) begin n_fail++; $display("FAIL idle_accepts: got %0d want 0", n_acc); end
  endtask

  task automatic test_ordered_stream();
    logic [W-1:0]   words [5];
    logic [2*W-1:0] pairs [5];
    int pbase, abase, drops, guard;
    words = '{16'h0000, 16'hFFFF, 16'hFA43, 16'h0131, 16'hC435};
    pairs = '{32'h0000FFFF, 32'hFFFF0000, 32'hFA4305BC, 32'h0131FECE, 32'hC4353BCA};
    pbase = n_pop; abase = n_acc; drops = 0;
    enable = 1'b1; out_ready = 1'b1; urng_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      urng_valid = 1'b1; urng_data = words[i];
      guard = 0;
      while (!urng_ready && guard < 10) begin drops++; tick(); guard++; end
      tick();
    end
    urng_valid = 1'b0;
    guard = 0;
    while (n_pop - pbase < 5 && guard < 20) begin tick(); guard++; end
    n_tests++; if (drops != 0) begin n_fail++; $display("FAIL stream_ready_drop: got %0d low cycles want 0", drops); end
    n_tests++; if (n_pop - pbase != 5) begin n_fail++; $display("FAIL stream_pop_count: got %0d want 5", n_pop - pbase); end
    for (int i = 0; i < 5; i++) begin
      if (pop_q.size() > pbase + i && acc_edge_q.size() > abase + i) begin
        n_tests++;
        if (pop_q[pbase+i] !== pairs[i]) begin
          n_fail++; $display("FAIL stream_pair%0d: got %h want %h", i, pop_q[pbase+i], pairs[i]);
        end
        n_tests++;
        if (pop_edge_q[pbase+i] - acc_edge_q[abase+i] != PIPE_LAT + 1) begin
          n_fail++; $display("FAIL stream_latency%0d: got %0d want %0d", i,
                             pop_edge_q[pbase+i] - acc_edge_q[abase+i], PIPE_LAT + 1);
        end
      end
    end
    n_tests++; if (pair_cnt !== 16'(pbase + 5)) begin n_fail++; $display("FAIL stream_pair_cnt: got %0d want %0d", pair_cnt, pbase + 5); end
  endtask

  task automatic test_backpressure();
    int abase, pbase, guard, bad;
    logic [2*W-1:0] head;
    abase = n_acc; pbase = n_pop;
    enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      urng_valid = 1'b1; urng_data = W'($urandom);
      tick();
    end
    n_tests++; if (n_acc - abase != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", n_acc - abase, DEPTH); end
    n_tests++; if (urng_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", urng_ready); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    head = {out_g0, out_g1};
    tick(); tick();
    n_tests++; if ({out_g0, out_g1} !== head) begin n_fail++; $display("FAIL bp_head_stable: got %h want %h", {out_g0, out_g1}, head); end
    if (acc_q.size() > abase) begin
      n_tests++;
      if (head !== exp_pair(acc_q[abase])) begin n_fail++; $display("FAIL bp_head_value: got %h want %h", head, exp_pair(acc_q[abase])); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin urng_data = W'($urandom); tick(); end
    urng_valid = 1'b0;
    guard = 0;
    while (n_pop < n_acc && guard < 30) begin tick(); guard++; end
    n_tests++; if (n_pop != n_acc) begin n_fail++; $display("FAIL bp_drain: popped %0d want %0d", n_pop, n_acc); end
    if (acc_edge_q.size() > abase + DEPTH && pop_edge_q.size() > pbase) begin
      n_tests++;
      if (acc_edge_q[abase+DEPTH] != pop_edge_q[pbase] + 1) begin
        n_fail++; $display("FAIL bp_resume: accept edge %0d want %0d", acc_edge_q[abase+DEPTH], pop_edge_q[pbase] + 1);
      end
    end
    bad = 0;
    for (int i = pbase; i < pop_q.size() && i < acc_q.size(); i++)
      if (pop_q[i] !== exp_pair(acc_q[i])) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_order: %0d wrong pairs want 0", bad); end
  endtask

  task automatic test_random();
    int pbase, k_push, guard, bad, bad_rdy, bad_vld;
    logic exp_ready, exp_valid;
    pbase = n_pop; k_push = n_acc; bad_rdy = 0; bad_vld = 0;
    enable = 1'b1;
    for (int i = 0; i < 400; i++) begin
      urng_valid = (($urandom % 4) != 0);
      out_ready  = (($urandom % 3) != 0);
      urng_data  = W'($urandom);
      while (k_push < acc_edge_q.size() && acc_edge_q[k_push] + PIPE_LAT <= cyc) k_push++;
      exp_ready = ((n_acc - n_pop) < DEPTH);
      exp_valid = ((k_push - n_pop) > 0);
      n_tests++;
      if (urng_ready !== exp_ready) begin
        n_fail++; bad_rdy++;
        if (bad_rdy < 4) $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, urng_ready, exp_ready);
      end
      n_tests++;
      if (out_valid !== exp_valid) begin
        n_fail++; bad_vld++;
        if (bad_vld < 4) $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, out_valid, exp_valid);
      end
      tick();
    end
    urng_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (n_pop < n_acc && guard < 30) begin tick(); guard++; end
    n_tests++; if (n_pop != n_acc) begin n_fail++; $display("FAIL rand_drain: popped %0d want %0d", n_pop, n_acc); end
    bad = 0;
    for (int i = pbase; i < pop_q.size() && i < acc_q.size(); i++)
      if (pop_q[i] !== exp_pair(acc_q[i])) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_order: %0d wrong pairs want 0", bad); end
  endtask

  task automatic test_drain();
    int abase, guard, nd;
    logic [15:0] cnt0;
    enable = 1'b1; out_ready = 1'b0;
    urng_valid = 1'b1; urng_data = 16'h0131;
    guard = 0;
    while (!urng_ready && guard < 10) begin tick(); guard++; end
    tick();
    abase = n_acc;
    urng_valid = 1'b0; enable = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b1 || urng_ready !== 1'b0) begin n_fail++; $display("FAIL drain_state: busy=%b ready=%b want 1/0", busy, urng_ready); end
    urng_valid = 1'b1; urng_data = W'($urandom);
    nd = 0;
    while (busy && nd < 10) begin tick(); nd++; end
    n_tests++; if (nd != 2) begin n_fail++; $display("FAIL drain_cycles: got %0d want 2", nd); end
    n_tests++; if (n_acc != abase) begin n_fail++; $display("FAIL drain_accepts: got %0d want 0", n_acc - abase); end
    n_tests++; if (out_valid !== 1'b1 || {out_g0, out_g1} !== 32'h0131FECE) begin
      n_fail++; $display("FAIL drain_buffered: valid=%b pair=%h want 1/0131fece", out_valid, {out_g0, out_g1});
    end
    urng_valid = 1'b0; out_ready = 1'b1;
    cnt0 = pair_cnt;
    tick();
    n_tests++; if (pop_q.size() == 0 || pop_q[$] !== 32'h0131FECE) begin
      n_fail++; $display("FAIL drain_pop: got %h want 0131fece", (pop_q.size() > 0) ? pop_q[$] : 32'h0);
    end
    n_tests++; if (pair_cnt !== cnt0 + 16'd1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_after_pop: cnt=%0d valid=%b want %0d/0", pair_cnt, out_valid, cnt0 + 16'd1);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    enable = 1'b1; out_ready = 1'b0; urng_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin urng_valid = 1'b1; urng_data = W'($urandom); tick(); end
    urng_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || n_acc - n_pop != 3) begin
      n_fail++; $display("FAIL mrst_setup: valid=%b outstanding=%0d want 1/3", out_valid, n_acc - n_pop);
    end
    #2; reset = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || {out_g0, out_g1} !== 32'h0) begin
      n_fail++; $display("FAIL mrst_async: valid=%b pair=%h want 0/0", out_valid, {out_g0, out_g1});
    end
    n_tests++; if (busy !== 1'b0 || urng_ready !== 1'b0 || pair_cnt !== 16'h0 || u1 !== 16'h0) begin
      n_fail++; $display("FAIL mrst_ctrl: busy=%b ready=%b cnt=%h u1=%h want all 0", busy, urng_ready, pair_cnt, u1);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; enable = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin if (out_valid) seen++; tick(); end
    n_tests++; if (seen != 0 || n_pop != 0) begin n_fail++; $display("FAIL mrst_stale: valid cycles=%0d pops=%0d want 0/0", seen, n_pop); end
    n_tests++; if (pair_cnt !== 16'h0) begin n_fail++; $display("FAIL mrst_cnt: got %h want 0", pair_cnt); end
  endtask

  task automatic test_counter_wrap();
    int guard, bad;
    bit checked;
    enable = 1'b1; out_ready = 1'b1; urng_valid = 1'b0;
    tick();
    guard = 0; checked = 1'b0;
    while (n_pop < 65536 && guard < 70000) begin
      urng_valid = (n_acc < 65536);
      urng_data  = W'($urandom);
      if (n_pop == 65535 && !checked) begin
        checked = 1'b1;
        n_tests++; if (pair_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h want ffff", pair_cnt); end
      end
      tick(); guard++;
    end
    urng_valid = 1'b0;
    n_tests++; if (n_pop != 65536) begin n_fail++; $display("FAIL wrap_pops: got %0d want 65536", n_pop); end
    n_tests++; if (pair_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", pair_cnt); end
    bad = 0;
    for (int i = 0; i < pop_q.size() && i < acc_q.size(); i++)
      if (pop_q[i] !== exp_pair(acc_q[i])) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wrap_data: %0d wrong pairs want 0", bad); end
    urng_valid = 1'b1; urng_data = 16'h5A5A;
    tick();
    urng_valid = 1'b0;
    guard = 0;
    while (n_pop < n_acc && guard < 10) begin tick(); guard++; end
    n_tests++; if (pair_cnt !== 16'h0001 || pop_q[$] !== 32'h5A5AA5A5) begin
      n_fail++; $display("FAIL wrap_after: cnt=%h pair=%h want 0001/5a5aa5a5", pair_cnt, pop_q[$]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ordered_stream();
    test_backpressure();
    test_random();
    test_drain();
    test_mid_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
